adc_frame_sender: RTL and testbench

//  Multi-channel successor to the single-channel ADC sender. Takes one snapshot of NUM_CH

---
 rtl/adc_pkg.sv | 17 +
 rtl/adc_ch_serializer.sv | 45 ++++
 rtl/adc_frame_sender.sv | 141 ++++++++++++++
 tb/tb_adc_frame_sender.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_pkg.sv
`default_nettype none
// adc_pkg: FSM state type and frame-length helper shared by the ADC frame sender. Rev 1.0
package adc_pkg;

  typedef enum logic [2:0] {IDLE, ARM, WAIT_EN, SEND, SYNC, GAP} state_t;

  localparam int unsigned BASE_LEN = 16;

  function automatic int unsigned mode_to_len(input logic [2:0] mode, input int unsigned max_log2);
    int unsigned len;
    len = BASE_LEN << mode;
    if (len > (32'd1 << max_log2)) len = 32'd1 << max_log2;
    return len;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adc_ch_serializer.sv
`default_nettype none
// adc_ch_serializer: holds one snapshot and presents it channel-by-channel on a valid/ready stage. Rev 1.0
module adc_ch_serializer #(
  parameter int DATA_W = 16,
  parameter int NUM_CH = 16,
  parameter int CH_W   = $clog2(NUM_CH)
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     load,
  input  logic [NUM_CH*DATA_W-1:0] snapshot,
  input  logic                     out_ready,
  output logic                     out_valid,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     last_ch_done
);

  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  logic [NUM_CH*DATA_W-1:0] hold;

  assign out_data     = hold[DATA_W*out_ch +: DATA_W];
  assign last_ch_done = out_valid && out_ready && (out_ch == LAST_CH);

  // A load may coincide with the last-channel handshake, so it takes priority.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      hold      <= '0;
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else if (load) begin
      hold      <= snapshot;
      out_valid <= 1'b1;
      out_ch    <= '0;
    end else if (last_ch_done) begin
      out_valid <= 1'b0;
      out_ch    <= '0;
    end else if (out_valid && out_ready) begin
      out_ch <= out_ch + 1'b1;
    end
  end

endmodule
`default_nettype wire

// File: rtl/adc_frame_sender.sv
`default_nettype none
// adc_frame_sender: serialises NUM_CH-wide ADC snapshots into framed words with eof marker and sync pulse. Rev 1.0
module adc_frame_sender
  import adc_pkg::*;
#(
  parameter int DATA_W       = 16,
  parameter int NUM_CH       = 16,
  parameter int CH_W         = $clog2(NUM_CH),
  parameter int MAX_LEN_LOG2 = 8,
  parameter int SYNC_LEN     = 2
) (
  input  logic                     clk,
  input  logic                     reset_n,
  input  logic                     en,
  input  logic [2:0]               sample_mode,
  input  logic                     in_valid,
  input  logic [NUM_CH*DATA_W-1:0] in_data,
  output logic                     in_ready,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [DATA_W-1:0]        out_data,
  output logic [CH_W-1:0]          out_ch,
  output logic                     out_sof,
  output logic                     out_eof,
  output logic                     sync,
  output logic                     busy,
  output logic                     overrun
);

  localparam int LEN_W  = MAX_LEN_LOG2 + 1;
  localparam int SYNC_W = $clog2(SYNC_LEN) + 1;
  localparam logic [CH_W-1:0] LAST_CH = CH_W'(NUM_CH - 1);

  state_t            state;
  logic [LEN_W-1:0]  frame_len;
  logic [LEN_W-1:0]  snap_cnt;
  logic [SYNC_W-1:0] sync_cnt;
  logic              stop_pend;
  logic              word_sent;
  logic              last_ch_done;
  logic              load;
  logic              eof_hs;

  assign out_sof  = out_valid && (out_ch == '0) && (snap_cnt == '0);
  assign out_eof  = out_valid && (out_ch == LAST_CH) &&
                    ((snap_cnt == frame_len - 1'b1) || stop_pend);
  assign eof_hs   = out_eof && out_ready;
  // Refill in the same cycle the last channel leaves, unless that word closes the frame.
  assign in_ready = (state == SEND) && en && !stop_pend &&
                    (!out_valid || (last_ch_done && !out_eof));
  assign load     = in_valid && in_ready;

  adc_ch_serializer #(
    .DATA_W (DATA_W),
    .NUM_CH (NUM_CH),
    .CH_W   (CH_W)
  ) u_ser (
    .clk          (clk),
    .reset_n      (reset_n),
    .load         (load),
    .snapshot     (in_data),
    .out_ready    (out_ready),
    .out_valid    (out_valid),
    .out_data     (out_data),
    .out_ch       (out_ch),
    .last_ch_done (last_ch_done)
  );

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      frame_len <= '0;
      snap_cnt  <= '0;
      sync_cnt  <= '0;
      stop_pend <= 1'b0;
      word_sent <= 1'b0;
      sync      <= 1'b0;
      busy      <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      overrun <= (state == SEND) && in_valid && !in_ready;
      case (state)
        IDLE: begin
          state <= ARM;
          busy  <= 1'b1;
        end
        ARM: begin
          frame_len <= LEN_W'(mode_to_len(sample_mode, MAX_LEN_LOG2));
          snap_cnt  <= '0;
          word_sent <= 1'b0;
          stop_pend <= 1'b0;
          state     <= WAIT_EN;
          busy      <= 1'b0;
        end
        WAIT_EN: begin
          stop_pend <= 1'b0;
          if (en) begin
            state <= SEND;
            busy  <= 1'b1;
          end
        end
        SEND: begin
          if (out_valid && out_ready) word_sent <= 1'b1;
          if (!en) stop_pend <= 1'b1;
          if (last_ch_done) snap_cnt <= snap_cnt + 1'b1;
          if (eof_hs) begin
            state    <= SYNC;
            sync     <= 1'b1;
            sync_cnt <= '0;
          end else if (!out_valid && (!en || stop_pend)) begin
            // Stopping with nothing in hold: a partial frame still gets its sync pulse.
            if (word_sent) begin
              state    <= SYNC;
              sync     <= 1'b1;
              sync_cnt <= '0;
            end else begin
              state <= WAIT_EN;
              busy  <= 1'b0;
            end
          end
        end
        SYNC: begin
          if (sync_cnt == SYNC_W'(SYNC_LEN - 1)) begin
            state <= GAP;
            sync  <= 1'b0;
          end else begin
            sync_cnt <= sync_cnt + 1'b1;
          end
        end
        GAP: state <= ARM;
        default: begin
          state <= IDLE;
          busy  <= 1'b0;
          sync  <= 1'b0;
        end
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_adc_frame_sender.sv
`default_nettype none
// tb_adc_frame_sender: table-driven frame scenarios with a word-stream scoreboard. Rev 1.0
module tb_adc_frame_sender;

  localparam int DATA_W   = 16;
  localparam int NUM_CH   = 16;
  localparam int CH_W     = 4;
  localparam int MAXL     = 8;
  localparam int SYNC_LEN = 2;
  localparam int W        = NUM_CH * DATA_W;

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              en = 1'b0;
  logic [2:0]        sample_mode = 3'd0;
  logic              in_valid = 1'b0;
  logic [W-1:0]      in_data = '0;
  logic              out_ready = 1'b0;
  logic              in_ready, out_valid, out_sof, out_eof, sync, busy, overrun;
  logic [DATA_W-1:0] out_data;
  logic [CH_W-1:0]   out_ch;

  adc_frame_sender #(
    .DATA_W(DATA_W), .NUM_CH(NUM_CH), .MAX_LEN_LOG2(MAXL), .SYNC_LEN(SYNC_LEN)
  ) dut (
    .clk(clk), .reset_n(reset_n), .en(en), .sample_mode(sample_mode),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_ch(out_ch),
    .out_sof(out_sof), .out_eof(out_eof), .sync(sync), .busy(busy), .overrun(overrun)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  // Source/sink driver: vpat 0=always valid, 1=random, 2=only when ready; rpat 0=always, 1=toggle, 2=random
  int vpat = 0;
  int rpat = 0;
  bit drive = 1'b0;

  always @(posedge clk) begin
    #1;
    if (drive) begin
      case (rpat)
        0:       out_ready = 1'b1;
        1:       out_ready = ~out_ready;
        default: out_ready = 1'($urandom_range(0, 1));
      endcase
      for (int k = 0; k < W / 32; k++) in_data[k*32 +: 32] = $urandom;
      if (vpat == 0)      in_valid = 1'b1;
      else if (vpat == 1) in_valid = 1'($urandom_range(0, 1));
      else begin
        #1;
        in_valid = in_ready;
      end
    end
  end

  // Scoreboard: every accepted snapshot expands into NUM_CH words, ch 0 first.
  typedef struct packed {
    logic [CH_W-1:0]   ch;
    logic [DATA_W-1:0] d;
  } word_t;

  word_t expq[$];
  word_t w;
  int cyc = 0;
  int words = 0, sofs = 0, eofs = 0, eof_pos = 0, sync_run = 0, ovr = 0;
  int sof_cyc = 0, eof_cyc = 0, last_eof_cyc = 0, sof_gap = 0;
  int f_words, f_sofs, f_eofs, f_eofpos, f_sync, f_sof_cyc, f_eof_cyc;
  int frames_done = 0;
  bit stall = 1'b0, psync = 1'b0, psof = 1'b0;
  logic [DATA_W-1:0] pdata;
  logic [CH_W-1:0]   pch;

  always @(negedge clk) begin
    cyc++;
    if (!reset_n) begin
      expq.delete();
      stall = 1'b0; psync = 1'b0; psof = 1'b0;
      words = 0; sofs = 0; eofs = 0; eof_pos = 0; sync_run = 0;
    end else begin
      if (stall) begin
        check("stall_valid", out_valid, 1);
        if (out_valid) begin
          check("stall_data", out_data, pdata);
          check("stall_ch", out_ch, pch);
        end
      end
      if (out_valid && out_sof && !psof) begin
        sof_cyc = cyc;
        sof_gap = cyc - last_eof_cyc;
      end
      psof = out_valid && out_sof;
      if (out_valid && out_ready) begin
        if (expq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL extra_word: got ch %0d data %0d, expected no word", out_ch, out_data);
        end else begin
          w = expq.pop_front();
          check("word_data", out_data, w.d);
          check("word_ch", out_ch, w.ch);
        end
        check("word_sof", out_sof, words == 0);
        if (out_sof) sofs++;
        if (out_eof) begin
          eofs++;
          eof_pos = words + 1;
          eof_cyc = cyc;
          last_eof_cyc = cyc;
        end
        words++;
      end
      stall = out_valid && !out_ready;
      pdata = out_data;
      pch   = out_ch;
      if (in_valid && in_ready)
        for (int k = 0; k < NUM_CH; k++)
          expq.push_back('{ch: CH_W'(k), d: in_data[k*DATA_W +: DATA_W]});
      if (overrun) ovr++;
      if (sync) sync_run++;
      if (psync && !sync) begin
        f_words = words; f_sofs = sofs; f_eofs = eofs; f_eofpos = eof_pos;
        f_sync = sync_run; f_sof_cyc = sof_cyc; f_eof_cyc = eof_cyc;
        frames_done++;
        words = 0; sofs = 0; eofs = 0; sync_run = 0;
      end
      psync = sync;
    end
  end

  // ovr_exp: 0 = none expected, 1 = some expected, 2 = not checked
  typedef struct {
    logic [2:0] mode;
    logic [2:0] mode_mid;
    int         stop_snap;
    int         vp;
    int         rp;
    int         exp_words;
    int         ovr_exp;
    bit         ideal;
  } vec_t;

  vec_t tv[6];
  int   old_sof;

  task automatic do_reset();
    @(posedge clk); #1 reset_n = 1'b0;
    @(posedge clk); #1 reset_n = 1'b1;
  endtask

  initial begin
    tv[0] = '{3'd0, 3'd0, -1, 0, 0,  256, 1, 1'b1};
    tv[1] = '{3'd1, 3'd1, -1, 0, 1,  512, 1, 1'b0};
    tv[2] = '{3'd0, 3'd0,  3, 2, 2,   64, 0, 1'b0};
    tv[3] = '{3'd7, 3'd0, -1, 0, 0, 4096, 1, 1'b1};
    tv[4] = '{3'd2, 3'd5, -1, 1, 2, 1024, 2, 1'b0};
    tv[5] = '{3'd0, 3'd0,  0, 2, 1,   16, 0, 1'b0};

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_out_valid", out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_sync", sync, 0);
    check("rst_in_ready", in_ready, 0);
    check("rst_out_data", out_data, 0);

    for (int i = 0; i < 6; i++) begin
      drive = 1'b0; en = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      sample_mode = tv[i].mode;
      do_reset();
      vpat = tv[i].vp; rpat = tv[i].rp;
      ovr = 0; frames_done = 0; drive = 1'b1;
      repeat (4) @(posedge clk);
      @(negedge clk);
      check("wait_en_busy", busy, 0);
      check("wait_en_in_ready", in_ready, 0);
      check("wait_en_overrun", ovr, 0);
      @(posedge clk); #1 en = 1'b1;
      for (int c = 0; c < 20000 && frames_done == 0; c++) begin
        @(posedge clk); #1;
        if (tv[i].stop_snap >= 0 && en && out_valid && words == tv[i].stop_snap * NUM_CH + 7)
          en = 1'b0;
        if (words >= 64) sample_mode = tv[i].mode_mid;
      end
      check("frame_done", frames_done > 0, 1);
      check("frame_words", f_words, tv[i].exp_words);
      check("frame_eof_pos", f_eofpos, tv[i].exp_words);
      check("frame_eof_cnt", f_eofs, 1);
      check("frame_sof_cnt", f_sofs, 1);
      check("frame_sync_len", f_sync, SYNC_LEN);
      if (tv[i].ovr_exp == 0) check("overrun_none", ovr, 0);
      if (tv[i].ovr_exp == 1) check("overrun_seen", ovr > 0, 1);
      if (tv[i].ideal) check("back_to_back", f_eof_cyc - f_sof_cyc, tv[i].exp_words - 1);
      if (i == 0) begin
        // Next frame follows: 2 sync, 1 gap, arm, wait_en, accept, first word.
        old_sof = sof_cyc;
        for (int c = 0; c < 100 && sof_cyc == old_sof; c++) @(posedge clk);
        check("next_frame_sof_gap", sof_gap, SYNC_LEN + 5);
      end
    end

    // Reset while word 5 of snapshot 2 is on the bus, then restart cleanly.
    drive = 1'b0; en = 1'b0;
    sample_mode = 3'd0;
    do_reset();
    vpat = 0; rpat = 0; drive = 1'b1;
    @(posedge clk); #1 en = 1'b1;
    for (int c = 0; c < 500 && !(out_valid && words == 2 * NUM_CH + 5); c++) @(posedge clk);
    #1 reset_n = 1'b0;
    @(negedge clk);
    check("midrst_out_valid", out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", in_ready, 0);
    check("midrst_sof_eof", {out_sof, out_eof}, 0);
    check("midrst_sync_ovr", {sync, overrun}, 0);
    check("midrst_data_ch", {out_data, out_ch}, 0);
    @(posedge clk); #1 reset_n = 1'b1;
    for (int c = 0; c < 200 && words == 0; c++) @(posedge clk);
    @(negedge clk);
    check("restart_words", words > 0, 1);

    drive = 1'b0;
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
